bcd_to_bin_seq: RTL and testbench

- Sequential multi-digit BCD-to-binary converter for the calculator datapath.
- Generalises the fixed two-digit combinational converter to NDIGITS digits, processing one digit per clock as acc = acc*10 + digit, most significant digit first.
- Start/done handshake, invalid-digit and overflow flags; feeds the calculator's binary ALU from the keypad BCD registers.

---
 rtl/bcd_to_bin_seq.sv | 170 +++++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential NDIGITS-digit BCD to binary converter.
// One digit per clock, most significant first: acc = acc*10 + digit.
// Start/done handshake, sticky invalid-digit (err) and overflow (ovf) flags.
// Optional feature: define BCD_TO_BIN_SIGNED_EN to add sign_in and a
// two's-complement bin_out that is one bit wider than BIN_W.

// One accumulate step: acc*10 + digit at BIN_W+4 bits, truncated to BIN_W.
module bcd_to_bin_step #(
  parameter int BIN_W = 7
) (
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] acc_nxt,
  output logic             bad,
  output logic             ovf
);
  logic [BIN_W+3:0] wide;
  logic [3:0]       d;

  // acc*10 as (acc<<3)+(acc<<1); an invalid digit contributes 0
  always_comb begin
    bad     = (digit > 4'd9);
    d       = bad ? 4'd0 : digit;
    wide    = {1'b0, acc, 3'b000} + {3'b000, acc, 1'b0} + {{BIN_W{1'b0}}, d};
    acc_nxt = wide[BIN_W-1:0];
    ovf     = |wide[BIN_W+3:BIN_W];
  end
endmodule

module bcd_to_bin_seq #(
  parameter int NDIGITS = 2,
  parameter int BIN_W   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd_in,
`ifdef BCD_TO_BIN_SIGNED_EN
  input  logic                   sign_in,
  output logic [BIN_W:0]         bin_out,
`else
  output logic [BIN_W-1:0]       bin_out,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   ovf
);
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
`ifdef BCD_TO_BIN_SIGNED_EN
  localparam int OUT_W = BIN_W + 1;
`else
  localparam int OUT_W = BIN_W;
`endif

  typedef enum logic {IDLE, CONV} state_t;

  state_t               state_q, state_d;
  logic [4*NDIGITS-1:0] op_q, op_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BIN_W-1:0]     acc_q, acc_d;
  logic                 err_acc_q, err_acc_d;
  logic                 ovf_acc_q, ovf_acc_d;
  logic [OUT_W-1:0]     bin_d;
  logic                 err_d, ovf_d, done_d;
  logic                 sign_q, sign_d;

  logic [3:0]           digit;
  logic [BIN_W-1:0]     step_acc;
  logic                 step_bad, step_ovf;
  logic                 last;
  logic [OUT_W-1:0]     mag;

  // select the digit at the current index from the captured operand
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < NDIGITS; i++)
      if (idx_q == IDX_W'(i)) digit = op_q[i*4 +: 4];
  end

  bcd_to_bin_step #(.BIN_W(BIN_W)) u_step (
    .acc     (acc_q),
    .digit   (digit),
    .acc_nxt (step_acc),
    .bad     (step_bad),
    .ovf     (step_ovf)
  );

  assign last = (idx_q == '0);
  assign busy = (state_q == CONV);

  // next-state, datapath and result logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    err_acc_d = err_acc_q;
    ovf_acc_d = ovf_acc_q;
    sign_d    = sign_q;
    bin_d     = bin_out;
    err_d     = err;
    ovf_d     = ovf;
    done_d    = 1'b0;
    mag       = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = bcd_in;
          acc_d     = '0;
          err_acc_d = 1'b0;
          ovf_acc_d = 1'b0;
          idx_d     = IDX_W'(NDIGITS - 1);
`ifdef BCD_TO_BIN_SIGNED_EN
          sign_d    = sign_in;
`else
          sign_d    = 1'b0;
`endif
          state_d   = CONV;
        end
      end
      CONV: begin
        acc_d     = step_acc;
        err_acc_d = err_acc_q | step_bad;
        ovf_acc_d = ovf_acc_q | step_ovf;
        idx_d     = idx_q - 1'b1;
        if (last) begin
          // err wins: result and ovf are forced to zero
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = err_acc_d;
          ovf_d   = err_acc_d ? 1'b0 : ovf_acc_d;
          mag     = err_acc_d ? '0 : OUT_W'(step_acc);
          // negation of zero stays zero, so negative zero needs no special case
          bin_d   = sign_q ? (~mag + 1'b1) : mag;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and result registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      err_acc_q <= 1'b0;
      ovf_acc_q <= 1'b0;
      sign_q    <= 1'b0;
      bin_out   <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      err_acc_q <= err_acc_d;
      ovf_acc_q <= ovf_acc_d;
      sign_q    <= sign_d;
      bin_out   <= bin_d;
      err       <= err_d;
      ovf       <= ovf_d;
      done      <= done_d;
    end
  end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: a 2-digit and a 3-digit instance, directed
// cases followed by random operands checked against a decimal reference.
module tb_bcd_to_bin_seq;
`ifdef BCD_TO_BIN_SIGNED_EN
  localparam int OW = 8;
`else
  localparam int OW = 7;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start2, busy2, done2, err2, ovf2;
  logic [7:0]    bcd2;
  logic [OW-1:0] bin2;
  logic          start3, busy3, done3, err3, ovf3;
  logic [11:0]   bcd3;
  logic [OW-1:0] bin3;
`ifdef BCD_TO_BIN_SIGNED_EN
  logic          sign2, sign3;
`endif

  bcd_to_bin_seq #(.NDIGITS(2), .BIN_W(7)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bcd_in(bcd2),
`ifdef BCD_TO_BIN_SIGNED_EN
    .sign_in(sign2),
`endif
    .busy(busy2), .done(done2), .bin_out(bin2), .err(err2), .ovf(ovf2));

  bcd_to_bin_seq #(.NDIGITS(3), .BIN_W(7)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .bcd_in(bcd3),
`ifdef BCD_TO_BIN_SIGNED_EN
    .sign_in(sign3),
`endif
    .busy(busy3), .done(done3), .bin_out(bin3), .err(err3), .ovf(ovf3));

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Decimal value of the digits (invalid digits read as 0), reduced mod 2^bw,
  // then negated in bw+1 bits when signed.
  function automatic longint ref_out(input logic [31:0] bcd, input int nd, input int bw,
                                     input bit sg, output bit e, output bit o);
    longint v, mag, m;
    int d;
    v = 0; e = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = int'((bcd >> (4 * i)) & 32'hF);
      if (d > 9) begin e = 1; d = 0; end
      v = v * 10 + d;
    end
    m   = longint'(1) << bw;
    o   = !e && (v > m - 1);
    mag = e ? 0 : v % m;
    if (sg) return ((2 * m) - mag) % (2 * m);
    return mag;
  endfunction

  task automatic wait_done2(output int lat);
    lat = 0;
    while (!done2 && lat < 8) begin @(negedge clk); lat++; end
  endtask

  task automatic wait_done3(output int lat);
    lat = 0;
    while (!done3 && lat < 8) begin @(negedge clk); lat++; end
  endtask

  // Called at a negedge; returns at the negedge where done is high.
  task automatic conv2(input logic [7:0] bcd, input bit sg, input string tag);
    bit e, o; longint ev; int lat;
    ev = ref_out({24'h0, bcd}, 2, 7, sg, e, o);
    start2 = 1'b1; bcd2 = bcd;
`ifdef BCD_TO_BIN_SIGNED_EN
    sign2 = sg;
`endif
    @(negedge clk);
    start2 = 1'b0; bcd2 = 8'($urandom);
    chk({tag, " busy"}, busy2, 1);
    chk({tag, " early done"}, done2, 0);
    wait_done2(lat);
    chk({tag, " latency"}, lat, 2);
    chk({tag, " bin"}, bin2, ev);
    chk({tag, " err"}, err2, e);
    chk({tag, " ovf"}, ovf2, o);
    chk({tag, " idle"}, busy2, 0);
  endtask

  task automatic conv3(input logic [11:0] bcd, input bit sg, input string tag);
    bit e, o; longint ev; int lat;
    ev = ref_out({20'h0, bcd}, 3, 7, sg, e, o);
    start3 = 1'b1; bcd3 = bcd;
`ifdef BCD_TO_BIN_SIGNED_EN
    sign3 = sg;
`endif
    @(negedge clk);
    start3 = 1'b0; bcd3 = 12'($urandom);
    wait_done3(lat);
    chk({tag, " latency"}, lat, 3);
    chk({tag, " bin"}, bin3, ev);
    chk({tag, " err"}, err3, e);
    chk({tag, " ovf"}, ovf3, o);
  endtask

  initial begin
    int lat;
    bit sg;
    logic [7:0]  r2;
    logic [11:0] r3;
    rst = 1'b1; start2 = 1'b0; start3 = 1'b0; bcd2 = '0; bcd3 = '0;
`ifdef BCD_TO_BIN_SIGNED_EN
    sign2 = 1'b0; sign3 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst busy", busy2, 0);
    chk("rst done", done2, 0);
    chk("rst bin", bin2, 0);
    chk("rst err", err2, 0);
    chk("rst ovf", ovf2, 0);
    chk("rst3 bin", bin3, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic, then back-to-back start in the done cycle
    conv2(8'h59, 1'b0, "c59");
    chk("c59 val", bin2, 59);
    conv2(8'h99, 1'b0, "b2b99");
    chk("b2b99 val", bin2, 99);
    @(negedge clk);
    chk("done width", done2, 0);

    // invalid digit, then cleared by a clean conversion
    conv2(8'h5A, 1'b0, "c5A");
    chk("c5A err", err2, 1);
    conv2(8'h00, 1'b0, "c00");
    chk("c00 err", err2, 0);

    // 3-digit overflow boundary
    conv3(12'h128, 1'b0, "c128");
    chk("c128 ovf", ovf3, 1);
    chk("c128 bin", bin3, 0);
    conv3(12'h127, 1'b0, "c127");
    chk("c127 bin", bin3, 127);
    chk("c127 ovf", ovf3, 0);

    // start while busy is ignored
    @(negedge clk);
    start2 = 1'b1; bcd2 = 8'h42;
    @(negedge clk);
    start2 = 1'b1; bcd2 = 8'h11;
    @(negedge clk);
    start2 = 1'b0;
    wait_done2(lat);
    chk("ign latency", lat, 1);
    chk("ign bin", bin2, 42);
    @(negedge clk);
    chk("ign no restart", busy2, 0);
    chk("ign done low", done2, 0);

    // reset in the middle of a conversion
    start2 = 1'b1; bcd2 = 8'h37;
    @(negedge clk);
    start2 = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mrst busy", busy2, 0);
    chk("mrst done", done2, 0);
    chk("mrst bin", bin2, 0);
    chk("mrst err", err2, 0);
    chk("mrst ovf", ovf2, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst no done", done2, 0);
    end

`ifdef BCD_TO_BIN_SIGNED_EN
    conv2(8'h45, 1'b1, "neg45");
    chk("neg45 val", bin2, 211);
    conv2(8'h00, 1'b1, "negzero");
    chk("negzero val", bin2, 0);
`endif

    // random operands, mostly valid digits
    for (int k = 0; k < 30; k++) begin
      r2 = {4'($urandom_range(0, (k % 4 == 0) ? 15 : 9)), 4'($urandom_range(0, 9))};
`ifdef BCD_TO_BIN_SIGNED_EN
      sg = 1'($urandom);
`else
      sg = 1'b0;
`endif
      conv2(r2, sg, "rnd2");
    end
    for (int k = 0; k < 20; k++) begin
      r3 = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, (k % 5 == 0) ? 15 : 9))};
`ifdef BCD_TO_BIN_SIGNED_EN
      sg = 1'($urandom);
`else
      sg = 1'b0;
`endif
      conv3(r3, sg, "rnd3");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
